// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: widths, ALU function
// groups, the bubble function code and write-back select encodings.
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // alu_fun[5:4] selects the ALU function group
  localparam logic [1:0] ALU_GRP_ARITH = 2'b00;
  localparam logic [1:0] ALU_GRP_LOGIC = 2'b01;
  localparam logic [1:0] ALU_GRP_SHIFT = 2'b10;
  localparam logic [1:0] ALU_GRP_CMP   = 2'b11;

  localparam logic [5:0] ALUFUN_BUBBLE = 6'd0;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forward select: EX/MEM beats MEM/WB beats the stored value;
// register 0 is never forwarded.
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  input  logic              exm_regwr,
  input  logic [REG_AW-1:0] exm_wr_addr,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_regwr,
  input  logic [REG_AW-1:0] mwb_wr_addr,
  input  logic [DATA_W-1:0] mwb_data,
  output logic [DATA_W-1:0] fwd_data
);

  logic src_nz;
  assign src_nz = |src_addr;

  always_comb begin
    fwd_data = src_data;
    if (src_nz && exm_regwr && (exm_wr_addr == src_addr))
      fwd_data = exm_data;
    else if (src_nz && mwb_regwr && (mwb_wr_addr == src_addr))
      fwd_data = mwb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU, with operand forwarding
// from EX/MEM and MEM/WB and load-use hazard detection.
module id_ex_stage #(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_AW = id_ex_stage_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic [5:0]        id_alufun,
  input  logic              id_sign,
  input  logic              id_alusrc1,
  input  logic              id_alusrc2,
  input  logic              id_regwr,
  input  logic              id_memrd,
  input  logic              id_memwr,
  input  logic [1:0]        id_memtoreg,
  input  logic              exm_regwr,
  input  logic [REG_AW-1:0] exm_wr_addr,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_regwr,
  input  logic [REG_AW-1:0] mwb_wr_addr,
  input  logic [DATA_W-1:0] mwb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_fun,
  output logic              alu_sign,
  output logic [DATA_W-1:0] ex_rt_fwd,
  output logic              ex_valid,
  output logic              ex_regwr,
  output logic              ex_memrd,
  output logic              ex_memwr,
  output logic [1:0]        ex_memtoreg,
  output logic [REG_AW-1:0] ex_wr_addr,
  output logic              load_use
);
  import id_ex_stage_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] wr_addr;
    logic [5:0]        alufun;
    logic              sign;
    logic              alusrc1;
    logic              alusrc2;
    logic              regwr;
    logic              memrd;
    logic              memwr;
    logic [1:0]        memtoreg;
  } stage_t;

  stage_t            stage_q, stage_d;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src_addr(stage_q.rs_addr), .src_data(stage_q.rs_data),
    .exm_regwr(exm_regwr), .exm_wr_addr(exm_wr_addr), .exm_data(exm_data),
    .mwb_regwr(mwb_regwr), .mwb_wr_addr(mwb_wr_addr), .mwb_data(mwb_data),
    .fwd_data(fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src_addr(stage_q.rt_addr), .src_data(stage_q.rt_data),
    .exm_regwr(exm_regwr), .exm_wr_addr(exm_wr_addr), .exm_data(exm_data),
    .mwb_regwr(mwb_regwr), .mwb_wr_addr(mwb_wr_addr), .mwb_data(mwb_data),
    .fwd_data(fwd_rt)
  );

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d        = '0;
      stage_d.alufun = ALUFUN_BUBBLE;
    end else if (stall) begin
      // producers may retire while we hold; capture what they forwarded
      stage_d.rs_data = fwd_rs;
      stage_d.rt_data = fwd_rt;
    end else begin
      stage_d.valid    = id_valid;
      stage_d.rs_addr  = id_rs_addr;
      stage_d.rt_addr  = id_rt_addr;
      stage_d.rs_data  = id_rs_data;
      stage_d.rt_data  = id_rt_data;
      stage_d.imm      = id_imm;
      stage_d.shamt    = id_shamt;
      stage_d.wr_addr  = id_wr_addr;
      stage_d.alufun   = id_alufun;
      stage_d.sign     = id_sign;
      stage_d.alusrc1  = id_alusrc1;
      stage_d.alusrc2  = id_alusrc2;
      stage_d.regwr    = id_regwr;
      stage_d.memrd    = id_memrd;
      stage_d.memwr    = id_memwr;
      stage_d.memtoreg = id_memtoreg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign alu_a       = stage_q.alusrc1 ? {{(DATA_W-5){1'b0}}, stage_q.shamt} : fwd_rs;
  assign alu_b       = stage_q.alusrc2 ? stage_q.imm : fwd_rt;
  assign ex_rt_fwd   = fwd_rt;
  assign alu_fun     = stage_q.alufun;
  assign alu_sign    = stage_q.sign;
  assign ex_valid    = stage_q.valid;
  assign ex_regwr    = stage_q.regwr;
  assign ex_memrd    = stage_q.memrd;
  assign ex_memwr    = stage_q.memwr;
  assign ex_memtoreg = stage_q.memtoreg;
  assign ex_wr_addr  = stage_q.wr_addr;

  assign load_use = stage_q.valid & stage_q.memrd & (|stage_q.wr_addr) &
                    ((stage_q.wr_addr == id_rs_addr) | (stage_q.wr_addr == id_rt_addr));

endmodule
